// File: rtl/decoder1to2_pkg.sv
// Shared definitions for the registered 1-to-2 decoder: lane limit, reset value
// and the decode function used by every lane.
package decoder1to2_pkg;

  localparam int LANES_MAX = 64;

  localparam logic [1:0] DEC_RST_VAL = 2'b00;

  // Returns {o1, o0}; at most one bit is ever set.
  function automatic logic [1:0] decode1to2(input logic en, input logic i);
    return {en & i, en & ~i};
  endfunction

endpackage

// File: rtl/decoder1to2_lane.sv
// Single-bit 1-to-2 decoder lane. Registered by default; defining
// DECODER1TO2_COMB_OUT_EN makes it combinational with a reset gate.
module decoder1to2_lane
  import decoder1to2_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output logic o1,
  output logic o0,
  input  logic i,
  input  logic en
);

`ifdef DECODER1TO2_COMB_OUT_EN
  logic [1:0] dec;

  // Zero-latency path; rst still wins so downstream selects drop immediately.
  assign dec      = rst ? DEC_RST_VAL : decode1to2(en, i);
  assign {o1, o0} = dec;
`else
  logic [1:0] dec_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= DEC_RST_VAL;
    end else begin
      dec_q <= decode1to2(en, i);
    end
  end

  assign {o1, o0} = dec_q;
`endif

endmodule

// File: rtl/decoder1to2_with_enable.sv
// LANES independent 1-to-2 decoders with per-lane enable (legal LANES 1..64).
// Optional macro DECODER1TO2_COMB_OUT_EN selects zero-latency outputs.
module decoder1to2_with_enable
  import decoder1to2_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [LANES-1:0] o1,
  output logic [LANES-1:0] o0,
  input  logic [LANES-1:0] i,
  input  logic [LANES-1:0] en
);

  // Lanes share only clk and rst; there is no cross-lane logic.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    decoder1to2_lane u_lane (
      .clk (clk),
      .rst (rst),
      .o1  (o1[k]),
      .o0  (o0[k]),
      .i   (i[k]),
      .en  (en[k])
    );
  end

endmodule

// File: tb/tb_decoder1to2_with_enable.sv
// Bench for decoder1to2_with_enable: a 1-lane and a 4-lane instance checked
// against a per-lane select model; inputs change on negedge, outputs sampled after posedge.
module tb_decoder1to2_with_enable;

  logic       clk;
  logic       rst;
  logic       en1, i1, o1_1, o0_1;
  logic [3:0] en4, i4, o1_4, o0_4;

  int errors = 0;
  int checks = 0;

  decoder1to2_with_enable #(.LANES(1)) dut1 (
    .clk (clk), .rst (rst), .o1 (o1_1), .o0 (o0_1), .i (i1), .en (en1)
  );

  decoder1to2_with_enable #(.LANES(4)) dut4 (
    .clk (clk), .rst (rst), .o1 (o1_4), .o0 (o0_4), .i (i4), .en (en4)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1;
    en1 = 1'b0;
    i1  = 1'b0;
    en4 = 4'h0;
    i4  = 4'h0;
  end

  // Reference: each enabled lane picks output index i (1 -> o1, 0 -> o0).
  function automatic logic [3:0] ref_o1(input logic r, input logic [3:0] e, input logic [3:0] s);
    logic [3:0] res;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      int sel;
      sel = (r || !e[k]) ? -1 : (s[k] ? 1 : 0);
      if (sel == 1) res[k] = 1'b1;
    end
    return res;
  endfunction

  function automatic logic [3:0] ref_o0(input logic r, input logic [3:0] e, input logic [3:0] s);
    logic [3:0] res;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      int sel;
      sel = (r || !e[k]) ? -1 : (s[k] ? 1 : 0);
      if (sel == 0) res[k] = 1'b1;
    end
    return res;
  endfunction

  // driver: apply inputs at negedge, return 1 time unit after the sampling edge
  task automatic apply(input logic r, input logic e1, input logic s1,
                       input logic [3:0] e4, input logic [3:0] s4);
    @(negedge clk);
    rst = r;
    en1 = e1;
    i1  = s1;
    en4 = e4;
    i4  = s4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
      checks++;
      if ({o1_1, o0_1} !== 2'b00) begin
        errors++;
        $display("FAIL reset_l1 cyc%0d: got o1=%b o0=%b want 0 0", c, o1_1, o0_1);
      end
      checks++;
      if ({o1_4, o0_4} !== 8'h00) begin
        errors++;
        $display("FAIL reset_l4 cyc%0d: got o1=%b o0=%b want 0000 0000", c, o1_4, o0_4);
      end
    end
    apply(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
    checks++;
    if ({o1_1, o0_1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got o1=%b o0=%b want 1 0", o1_1, o0_1);
    end
  endtask

  task automatic test_disabled();
    for (int s = 0; s < 2; s++) begin
      apply(1'b0, 1'b0, s[0], 4'h0, {4{s[0]}});
      checks++;
      if ({o1_1, o0_1} !== 2'b00) begin
        errors++;
        $display("FAIL disabled i=%0d: got o1=%b o0=%b want 0 0", s, o1_1, o0_1);
      end
    end
  endtask

  task automatic test_enabled();
    apply(1'b0, 1'b1, 1'b0, 4'hF, 4'h0);
    checks++;
    if ({o1_1, o0_1} !== 2'b01) begin
      errors++;
      $display("FAIL enabled_i0: got o1=%b o0=%b want 0 1", o1_1, o0_1);
    end
    apply(1'b0, 1'b1, 1'b1, 4'hF, 4'hF);
    checks++;
    if ({o1_1, o0_1} !== 2'b10) begin
      errors++;
      $display("FAIL enabled_i1: got o1=%b o0=%b want 1 0", o1_1, o0_1);
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b1, 1'b1, 4'h5, 4'h3);
    checks++;
    if ({o1_1, o0_1} !== 2'b10) begin
      errors++;
      $display("FAIL mid_pre: got o1=%b o0=%b want 1 0", o1_1, o0_1);
    end
    apply(1'b1, 1'b1, 1'b1, 4'h5, 4'h3);
    checks++;
    if ({o1_1, o0_1, o1_4, o0_4} !== 10'b0) begin
      errors++;
      $display("FAIL mid_rst: got o1=%b o0=%b o1_4=%b o0_4=%b want all 0",
               o1_1, o0_1, o1_4, o0_4);
    end
    apply(1'b0, 1'b1, 1'b1, 4'h5, 4'h3);
    checks++;
    if ({o1_1, o0_1} !== 2'b10 || o1_4 !== 4'b0001 || o0_4 !== 4'b0100) begin
      errors++;
      $display("FAIL mid_resume: got o1=%b o0=%b o1_4=%b o0_4=%b want 1 0 0001 0100",
               o1_1, o0_1, o1_4, o0_4);
    end
  endtask

  task automatic test_lanes();
    apply(1'b0, 1'b0, 1'b0, 4'b1010, 4'b1100);
    checks++;
    if (o1_4 !== 4'b1000 || o0_4 !== 4'b0010) begin
      errors++;
      $display("FAIL lanes_fixed: got o1=%b o0=%b want 1000 0010", o1_4, o0_4);
    end
    // exhaustive sweep of every en/i combination across four lanes
    for (int e = 0; e < 16; e++) begin
      for (int s = 0; s < 16; s++) begin
        logic [3:0] x1, x0;
        apply(1'b0, 1'b0, 1'b0, e[3:0], s[3:0]);
        x1 = ref_o1(1'b0, e[3:0], s[3:0]);
        x0 = ref_o0(1'b0, e[3:0], s[3:0]);
        checks++;
        if (o1_4 !== x1 || o0_4 !== x0 || (o1_4 & o0_4) !== 4'b0) begin
          errors++;
          $display("FAIL sweep en=%b i=%b: got o1=%b o0=%b want %b %b",
                   e[3:0], s[3:0], o1_4, o0_4, x1, x0);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_q[$];
    for (int n = 0; n < 300; n++) begin
      logic       r, e1, s1;
      logic [3:0] e4, s4, x1, x0, y1, y0;
      r  = ($urandom_range(0, 9) == 0);
      e1 = 1'($urandom_range(0, 1));
      s1 = 1'($urandom_range(0, 1));
      e4 = 4'($urandom_range(0, 15));
      s4 = 4'($urandom_range(0, 15));
      exp_q.push_back(ref_o1(r, e4, s4));
      exp_q.push_back(ref_o0(r, e4, s4));
      exp_q.push_back(ref_o1(r, {3'b0, e1}, {3'b0, s1}));
      exp_q.push_back(ref_o0(r, {3'b0, e1}, {3'b0, s1}));
      apply(r, e1, s1, e4, s4);
      x1 = exp_q.pop_front();
      x0 = exp_q.pop_front();
      y1 = exp_q.pop_front();
      y0 = exp_q.pop_front();
      checks++;
      if (o1_4 !== x1 || o0_4 !== x0) begin
        errors++;
        $display("FAIL rand_l4 #%0d rst=%b en=%b i=%b: got %b %b want %b %b",
                 n, r, e4, s4, o1_4, o0_4, x1, x0);
      end
      checks++;
      if (o1_1 !== y1[0] || o0_1 !== y0[0]) begin
        errors++;
        $display("FAIL rand_l1 #%0d rst=%b en=%b i=%b: got %b %b want %b %b",
                 n, r, e1, s1, o1_1, o0_1, y1[0], y0[0]);
      end
    end
  endtask

`ifdef DECODER1TO2_COMB_OUT_EN
  task automatic test_comb();
    @(negedge clk);
    rst = 1'b0;
    en1 = 1'b1;
    i1  = 1'b0;
    #1;
    checks++;
    if ({o1_1, o0_1} !== 2'b01) begin
      errors++;
      $display("FAIL comb_noedge: got o1=%b o0=%b want 0 1", o1_1, o0_1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({o1_1, o0_1} !== 2'b00) begin
      errors++;
      $display("FAIL comb_rst: got o1=%b o0=%b want 0 0", o1_1, o0_1);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_disabled();
    test_enabled();
    test_reset_mid();
    test_lanes();
    test_random();
`ifdef DECODER1TO2_COMB_OUT_EN
    test_comb();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
